mux2to1_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one 2:1 mux datapath between two requesters.
- Drives the mux select and the per-requester grants.
- Presents the selected requester's data to a single downstream consumer over a valid/ready handshake.
- Sits directly in front of the mux2to1 datapath; the select output S is the mux's select input.

---
 rtl/mux2to1_rr_arbiter.sv | 141 ++++++++++++++
 tb/tb_mux2to1_rr_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mux2to1_rr_arbiter.sv
// Round-robin owner of a shared 2:1 mux: grants, select and valid/ready output to one consumer.
// Optional MUX_ARB_HOLD_LIMIT_EN caps accepted beats per grant at MAX_BEATS when the other side waits.
module mux2to1_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] A1,
  input  logic             y_ready,
  output logic             gnt0,
  output logic             gnt1,
  output logic             S,
  output logic [WIDTH-1:0] Y,
  output logic             y_valid
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t state_q, state_d;
  logic   s_q, s_d;
  logic   lsp_q, lsp_d;
  logic   xfer;

  if (MAX_BEATS < 1 || MAX_BEATS > 255) begin : g_bad_max_beats
    $error("MAX_BEATS must be in 1..255");
  end

`ifdef MUX_ARB_HOLD_LIMIT_EN
  localparam logic [7:0] LIMIT = 8'(MAX_BEATS);
  logic [7:0] beat_q, beat_d;
`endif

  assign gnt0    = (state_q == GNT0);
  assign gnt1    = (state_q == GNT1);
  assign S       = s_q;
  assign Y       = s_q ? A1 : A0;
  assign y_valid = (gnt0 & req0) | (gnt1 & req1);
  assign xfer    = y_valid & y_ready;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    lsp_d   = lsp_q;
`ifdef MUX_ARB_HOLD_LIMIT_EN
    beat_d  = beat_q;
`endif
    case (state_q)
      IDLE: begin
        // lsp_q==1 means requester 1 was served last, so 0 wins a tie
        if (req0 && (!req1 || lsp_q)) begin
          state_d = GNT0;
          s_d     = 1'b0;
        end else if (req1) begin
          state_d = GNT1;
          s_d     = 1'b1;
        end
      end
      GNT0: begin
        if (!req0) begin
          lsp_d = 1'b0;
          if (req1) begin
            state_d = GNT1;
            s_d     = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
`ifdef MUX_ARB_HOLD_LIMIT_EN
        else if (xfer) begin
          if ((beat_q + 8'd1) == LIMIT) begin
            beat_d = '0;
            if (req1) begin
              lsp_d   = 1'b0;
              state_d = GNT1;
              s_d     = 1'b1;
            end
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
`endif
      end
      GNT1: begin
        if (!req1) begin
          lsp_d = 1'b1;
          if (req0) begin
            state_d = GNT0;
            s_d     = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
`ifdef MUX_ARB_HOLD_LIMIT_EN
        else if (xfer) begin
          if ((beat_q + 8'd1) == LIMIT) begin
            beat_d = '0;
            if (req0) begin
              lsp_d   = 1'b1;
              state_d = GNT0;
              s_d     = 1'b0;
            end
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
`ifdef MUX_ARB_HOLD_LIMIT_EN
    if (state_d != state_q) begin
      beat_d = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= 1'b0;
      lsp_q   <= 1'b1;
`ifdef MUX_ARB_HOLD_LIMIT_EN
      beat_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      lsp_q   <= lsp_d;
`ifdef MUX_ARB_HOLD_LIMIT_EN
      beat_q  <= beat_d;
`endif
    end
  end

endmodule

// File: tb/tb_mux2to1_rr_arbiter.sv
// Directed bench: expected Y beats queued by the stimulus, consumed by a transfer monitor.
module tb_mux2to1_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst, req0, req1, y_ready;
  logic [7:0] A0, A1, Y;
  logic       gnt0, gnt1, S, y_valid;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  mux2to1_rr_arbiter #(.WIDTH(8), .MAX_BEATS(4)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .A0(A0), .A1(A1),
    .y_ready(y_ready), .gnt0(gnt0), .gnt1(gnt1), .S(S), .Y(Y), .y_valid(y_valid)
  );

  task automatic cyc(input logic r, input logic q0, input logic q1,
                     input logic [7:0] a0, input logic [7:0] a1, input logic yr);
    @(posedge clk);
    #1;
    rst = r; req0 = q0; req1 = q1; A0 = a0; A1 = a1; y_ready = yr;
  endtask

  task automatic chk(input string name, input logic g0, input logic g1,
                     input logic s, input logic v);
    #1;
    checks++;
    if ({gnt0, gnt1, S, y_valid} !== {g0, g1, s, v}) begin
      errors++;
      $display("FAIL %s: got gnt0=%b gnt1=%b S=%b y_valid=%b, want %b %b %b %b",
               name, gnt0, gnt1, S, y_valid, g0, g1, s, v);
    end
  endtask

  task automatic chk_y(input string name, input logic [7:0] exp);
    checks++;
    if (Y !== exp) begin
      errors++;
      $display("FAIL %s: got Y=%h want %h", name, Y, exp);
    end
  endtask

  // Monitor: every accepted beat must match the oldest queued expectation
  initial begin
    forever begin
      @(negedge clk);
      if (y_valid === 1'b1 && y_ready === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL xfer: unexpected transfer Y=%h, none expected", Y);
        end else begin
          logic [7:0] e;
          e = sb.pop_front();
          if (Y !== e) begin
            errors++;
            $display("FAIL xfer: got Y=%h want %h", Y, e);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; A0 = 8'h11; A1 = 8'h22; y_ready = 1'b1;

    // Reset with both requesting
    cyc(1, 1, 1, 8'h11, 8'h22, 1);  chk("reset", 0, 0, 0, 0);  chk_y("reset_y", 8'h11);
    cyc(0, 1, 1, 8'h11, 8'h22, 0);  chk("reset2", 0, 0, 0, 0);
    cyc(0, 1, 1, 8'h11, 8'h22, 0);  chk("rst_release_gnt0", 1, 0, 0, 1);

    // Backpressure: no transfers, Y stable
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 8'h3C, 8'h22, 0);  chk("bp_hold", 1, 0, 0, 1);  chk_y("bp_y", 8'h3C);
    end

    // Burst from requester 0
    cyc(0, 1, 1, 8'h01, 8'h22, 1);  sb.push_back(8'h01);  chk("burst0", 1, 0, 0, 1);
    cyc(0, 1, 1, 8'h02, 8'h22, 1);  sb.push_back(8'h02);  chk("burst0", 1, 0, 0, 1);
    cyc(0, 1, 1, 8'h03, 8'h22, 1);  sb.push_back(8'h03);  chk("burst0", 1, 0, 0, 1);

    // Release with other waiting: direct switch, no idle cycle
    cyc(0, 0, 1, 8'h03, 8'h22, 1);  chk("release0", 1, 0, 0, 0);
    cyc(0, 0, 1, 8'h00, 8'hB1, 1);  sb.push_back(8'hB1);  chk("switch_gnt1", 0, 1, 1, 1);
    chk_y("switch_y", 8'hB1);
    cyc(0, 0, 1, 8'h00, 8'hB2, 1);  sb.push_back(8'hB2);  chk("gnt1_burst", 0, 1, 1, 1);
    cyc(0, 0, 0, 8'h00, 8'hB2, 1);  chk("release1", 0, 1, 1, 0);
    cyc(0, 0, 0, 8'h55, 8'hA5, 1);  chk("idle_s_holds", 0, 0, 1, 0);  chk_y("idle_y", 8'hA5);

    // Tie from IDLE after 1 was served: 0 wins
    cyc(0, 1, 1, 8'h44, 8'h66, 1);  chk("tie_idle", 0, 0, 1, 0);
    cyc(0, 1, 1, 8'h45, 8'h66, 1);  sb.push_back(8'h45);  chk("tie_gnt0", 1, 0, 0, 1);
    cyc(0, 0, 1, 8'h45, 8'h67, 0);  chk("release0b", 1, 0, 0, 0);
    cyc(0, 0, 1, 8'h45, 8'h67, 0);  chk("gnt1_stall", 0, 1, 1, 1);

    // Reset mid-burst while lsp=0
    cyc(1, 0, 1, 8'h45, 8'h67, 0);  chk("pre_reset", 0, 1, 1, 1);
    cyc(0, 1, 1, 8'h46, 8'h68, 1);  chk("mid_reset_idle", 0, 0, 0, 0);
    cyc(0, 0, 0, 8'h47, 8'h68, 1);  chk("lsp_after_reset", 1, 0, 0, 0);

    // Single requester 1
    cyc(0, 0, 1, 8'h00, 8'hA5, 1);  chk("single_idle", 0, 0, 0, 0);
    cyc(0, 0, 1, 8'h00, 8'hA5, 1);  sb.push_back(8'hA5);  chk("single_gnt1", 0, 1, 1, 1);
    chk_y("single_y", 8'hA5);
    cyc(0, 0, 0, 8'h00, 8'hA5, 1);  chk("single_rel", 0, 1, 1, 0);
    cyc(0, 0, 0, 8'h00, 8'hA5, 1);  chk("single_s_holds", 0, 0, 1, 0);

    // Hold limit with both requesting
    cyc(0, 1, 1, 8'hD0, 8'hE0, 1);  chk("hold_idle", 0, 0, 1, 0);
    for (int i = 1; i <= 6; i++) begin
      cyc(0, 1, 1, 8'(8'hD0 + i), 8'(8'hE0 + i), 1);
`ifdef MUX_ARB_HOLD_LIMIT_EN
      if (i <= 4) begin
        sb.push_back(8'(8'hD0 + i));  chk("hold_gnt0", 1, 0, 0, 1);
      end else begin
        sb.push_back(8'(8'hE0 + i));  chk("hold_forced_switch", 0, 1, 1, 1);
      end
`else
      sb.push_back(8'(8'hD0 + i));  chk("hold_gnt0_persist", 1, 0, 0, 1);
`endif
    end
    cyc(0, 0, 0, 8'h00, 8'h00, 1);
`ifdef MUX_ARB_HOLD_LIMIT_EN
    chk("hold_release", 0, 1, 1, 0);
    cyc(0, 1, 0, 8'hF0, 8'h00, 1);  chk("solo_idle", 0, 0, 1, 0);
`else
    chk("hold_release", 1, 0, 0, 0);
    cyc(0, 1, 0, 8'hF0, 8'h00, 1);  chk("solo_idle", 0, 0, 0, 0);
`endif

    // Lone requester keeps its grant past the beat limit
    for (int i = 1; i <= 6; i++) begin
      cyc(0, 1, 0, 8'(8'hF0 + i), 8'h00, 1);
      sb.push_back(8'(8'hF0 + i));  chk("solo_gnt0", 1, 0, 0, 1);
    end
    cyc(0, 0, 0, 8'h00, 8'h00, 1);

    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected beats never transferred, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
